// File: rtl/contador_seq_ctrl.sv
// rtl/contador_seq_ctrl.sv - command-driven sequencer for the 4-bit mode counter
//
// Takes one command (count mode, start value, number of wraps) over a
// valid/ready handshake. It loads the start value into the counter and then
// enables counting in the requested mode until the requested number of rco
// pulses has been seen. It reports done with the captured count, or err on an
// illegal mode, an abort or a watchdog timeout. Every output is decoded from
// registers only.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   cmd_valid_i/ready_o  command handshake; ready only while idle
//   cmd_mode_i           count mode 00/01/10; 11 (load) is rejected
//   cmd_start_i          value loaded into the counter before counting
//   cmd_wraps_i          rco pulses to wait for; 0 = load only
//   abort_i              cancels the command in flight
//   cnt_enable_o/mode_o/d_o   counter control
//   cnt_load_i/rco_i/q_i      counter status and value
//   busy_o               high whenever not idle
//   done_o, err_o        one-cycle completion / error pulses
//   final_q_o            counter value captured on completion
module contador_seq_ctrl #(
    parameter int WRAP_W  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_mode_i,
    input  logic [3:0]        cmd_start_i,
    input  logic [WRAP_W-1:0] cmd_wraps_i,
    input  logic              abort_i,
    output logic              cnt_enable_o,
    output logic [1:0]        cnt_mode_o,
    output logic [3:0]        cnt_d_o,
    input  logic              cnt_load_i,
    input  logic              cnt_rco_i,
    input  logic [3:0]        cnt_q_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [3:0]        final_q_o
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOAD_WAIT,
        S_COUNT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [3:0]        start_q, start_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;
    logic [WRAP_W-1:0] remaining_q, remaining_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              err_q, err_d;
    logic [3:0]        fq_q, fq_d;

    logic wd_active;
    logic progress;
    logic timeout;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            start_q     <= '0;
            wraps_q     <= '0;
            remaining_q <= '0;
            wd_q        <= '0;
            err_q       <= 1'b0;
            fq_q        <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            start_q     <= start_d;
            wraps_q     <= wraps_d;
            remaining_q <= remaining_d;
            wd_q        <= wd_d;
            err_q       <= err_d;
            fq_q        <= fq_d;
        end
    end

    // wd_q holds the number of cycles elapsed since the last progress event
    // (or since LOAD). The progress cycle itself leaves 1 behind, so err
    // arrives exactly TIMEOUT cycles after the last progress event.
    always_comb begin
        wd_active = (state_q == S_LOAD_WAIT) || (state_q == S_COUNT);
        progress  = ((state_q == S_LOAD_WAIT) && cnt_load_i) ||
                    ((state_q == S_COUNT) && cnt_rco_i);
        timeout   = wd_active && !progress && (wd_q >= WD_W'(TIMEOUT - 1));
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        start_d     = start_q;
        wraps_d     = wraps_q;
        remaining_d = remaining_q;
        err_d       = 1'b0;
        fq_d        = fq_q;

        if (state_q == S_LOAD) begin
            wd_d = WD_W'(1);
        end else if (wd_active) begin
            wd_d = progress ? WD_W'(1) : wd_q + WD_W'(1);
        end else begin
            wd_d = '0;
        end

        // Priority: abort, then timeout, then normal progress.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end else if (timeout) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        mode_d  = cmd_mode_i;
                        start_d = cmd_start_i;
                        wraps_d = cmd_wraps_i;
                        if (cmd_mode_i == MODE_LOAD) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    state_d = S_LOAD_WAIT;
                end
                S_LOAD_WAIT: begin
                    if (cnt_load_i) begin
                        if (wraps_q == '0) begin
                            state_d = S_DONE;
                            fq_d    = cnt_q_i;
                        end else begin
                            state_d     = S_COUNT;
                            remaining_d = wraps_q;
                        end
                    end
                end
                S_COUNT: begin
                    // remaining_q is never 0 here; the guard keeps it from wrapping.
                    if (cnt_rco_i && (remaining_q != '0)) begin
                        remaining_d = remaining_q - WRAP_W'(1);
                        if (remaining_q == WRAP_W'(1)) begin
                            state_d = S_DONE;
                            fq_d    = cnt_q_i;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        cmd_ready_o  = 1'b0;
        busy_o       = 1'b1;
        cnt_enable_o = 1'b0;
        cnt_mode_o   = 2'b00;
        cnt_d_o      = 4'h0;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
            end
            S_LOAD: begin
                cnt_enable_o = 1'b1;
                cnt_mode_o   = MODE_LOAD;
                cnt_d_o      = start_q;
            end
            S_LOAD_WAIT: begin
                cnt_mode_o = MODE_LOAD;
                cnt_d_o    = start_q;
            end
            S_COUNT: begin
                cnt_enable_o = 1'b1;
                cnt_mode_o   = mode_q;
                cnt_d_o      = start_q;
            end
            default: begin
            end
        endcase
    end

    assign done_o    = (state_q == S_DONE);
    assign err_o     = err_q;
    assign final_q_o = fq_q;

endmodule

// File: tb/tb_contador_seq_ctrl.sv
// tb/tb_contador_seq_ctrl.sv - self-checking bench for contador_seq_ctrl
module tb_contador_seq_ctrl;

    localparam int WRAP_W  = 4;
    localparam int TIMEOUT = 64;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [1:0]        cmd_mode_i;
    logic [3:0]        cmd_start_i;
    logic [WRAP_W-1:0] cmd_wraps_i;
    logic              abort_i;
    logic              cnt_enable_o;
    logic [1:0]        cnt_mode_o;
    logic [3:0]        cnt_d_o;
    logic              cnt_load_i;
    logic              cnt_rco_i;
    logic [3:0]        cnt_q_i;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [3:0]        final_q_o;

    contador_seq_ctrl #(.WRAP_W(WRAP_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_mode_i(cmd_mode_i), .cmd_start_i(cmd_start_i), .cmd_wraps_i(cmd_wraps_i),
        .abort_i(abort_i),
        .cnt_enable_o(cnt_enable_o), .cnt_mode_o(cnt_mode_o), .cnt_d_o(cnt_d_o),
        .cnt_load_i(cnt_load_i), .cnt_rco_i(cnt_rco_i), .cnt_q_i(cnt_q_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .final_q_o(final_q_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic              valid;
        logic [1:0]        mode;
        logic [3:0]        start;
        logic [WRAP_W-1:0] wraps;
        logic              abort;
        logic              load;
        logic              rco;
        logic [3:0]        q;
    } in_t;

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       en;
        logic [1:0] mode;
        logic [3:0] d;
        logic       done;
        logic       err;
        logic [3:0] fq;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
        out_t care;
    } vec_t;

    out_t  exp_q[$];
    out_t  care_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    localparam out_t ALL = '1;
    // DONE leaves counter mode/D unconstrained; only enable must be low.
    localparam out_t DONE_CARE = 15'b111_00_0000_11_1111;

    function automatic in_t mk_in(input logic valid, input logic [1:0] mode,
                                  input logic [3:0] start, input logic [WRAP_W-1:0] wraps,
                                  input logic abort, input logic load, input logic rco,
                                  input logic [3:0] q);
        in_t r;
        r = {valid, mode, start, wraps, abort, load, rco, q};
        return r;
    endfunction

    function automatic out_t mk_out(input logic ready, input logic busy, input logic en,
                                    input logic [1:0] mode, input logic [3:0] d,
                                    input logic done, input logic err, input logic [3:0] fq);
        out_t r;
        r = {ready, busy, en, mode, d, done, err, fq};
        return r;
    endfunction

    function automatic out_t idle_out(input logic err, input logic [3:0] fq);
        return mk_out(1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 1'b0, err, fq);
    endfunction

    function automatic out_t sample_out();
        out_t r;
        r = {cmd_ready_o, busy_o, cnt_enable_o, cnt_mode_o, cnt_d_o, done_o, err_o, final_q_o};
        return r;
    endfunction

    task automatic drive(input in_t v);
        cmd_valid_i = v.valid;
        cmd_mode_i  = v.mode;
        cmd_start_i = v.start;
        cmd_wraps_i = v.wraps;
        abort_i     = v.abort;
        cnt_load_i  = v.load;
        cnt_rco_i   = v.rco;
        cnt_q_i     = v.q;
    endtask

    task automatic check_front();
        out_t  e, m, a;
        string t;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: no expected record queued");
            return;
        end
        e = exp_q.pop_front();
        m = care_q.pop_front();
        t = tag_q.pop_front();
        a = sample_out();
        if (((a ^ e) & m) !== '0) begin
            n_bad++;
            $display("FAIL %s: got rdy=%b busy=%b en=%b mode=%b d=%h done=%b err=%b fq=%h, want rdy=%b busy=%b en=%b mode=%b d=%h done=%b err=%b fq=%h (care %h)",
                     t, a.ready, a.busy, a.en, a.mode, a.d, a.done, a.err, a.fq,
                     e.ready, e.busy, e.en, e.mode, e.d, e.done, e.err, e.fq, m);
        end
    endtask

    task automatic check_now(input out_t e, input out_t m, input string t);
        exp_q.push_back(e);
        care_q.push_back(m);
        tag_q.push_back(t);
        check_front();
    endtask

    // Called at a falling edge: drive, queue the expected result, compare it
    // at the next falling edge.
    task automatic step(input in_t v, input out_t e, input out_t m, input string t);
        drive(v);
        exp_q.push_back(e);
        care_q.push_back(m);
        tag_q.push_back(t);
        @(posedge clk_i);
        @(negedge clk_i);
        check_front();
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        vec_t  tbl[$];
        string tbl_tag[$];
        in_t   idle_in;
        in_t   v;
        in_t   c2;
        out_t  count_o;

        idle_in = mk_in(1'b0, 2'b00, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0, 4'h0);

        // Illegal mode, idle-state abort/flags, then a load-only command.
        tbl.push_back('{mk_in(1'b1, 2'b11, 4'h9, 4'd2, 1'b0, 1'b0, 1'b0, 4'h0), idle_out(1'b1, 4'h0), ALL});
        tbl_tag.push_back("illegal_err");
        tbl.push_back('{idle_in, idle_out(1'b0, 4'h0), ALL});
        tbl_tag.push_back("illegal_clear");
        tbl.push_back('{mk_in(1'b0, 2'b00, 4'h0, 4'd0, 1'b1, 1'b0, 1'b0, 4'h0), idle_out(1'b0, 4'h0), ALL});
        tbl_tag.push_back("abort_idle_ignored");
        tbl.push_back('{mk_in(1'b0, 2'b00, 4'h0, 4'd0, 1'b0, 1'b1, 1'b1, 4'h3), idle_out(1'b0, 4'h0), ALL});
        tbl_tag.push_back("flags_idle_ignored");
        tbl.push_back('{mk_in(1'b1, 2'b01, 4'h5, 4'd0, 1'b0, 1'b0, 1'b0, 4'h0),
                        mk_out(1'b0, 1'b1, 1'b1, 2'b11, 4'h5, 1'b0, 1'b0, 4'h0), ALL});
        tbl_tag.push_back("w0_load");
        tbl.push_back('{idle_in, mk_out(1'b0, 1'b1, 1'b0, 2'b11, 4'h5, 1'b0, 1'b0, 4'h0), ALL});
        tbl_tag.push_back("w0_load_wait");
        tbl.push_back('{mk_in(1'b0, 2'b00, 4'h0, 4'd0, 1'b0, 1'b0, 1'b1, 4'h5),
                        mk_out(1'b0, 1'b1, 1'b0, 2'b11, 4'h5, 1'b0, 1'b0, 4'h0), ALL});
        tbl_tag.push_back("w0_rco_ignored");
        tbl.push_back('{mk_in(1'b0, 2'b00, 4'h0, 4'd0, 1'b0, 1'b1, 1'b0, 4'h5),
                        mk_out(1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 1'b1, 1'b0, 4'h5), DONE_CARE});
        tbl_tag.push_back("w0_done");
        tbl.push_back('{idle_in, idle_out(1'b0, 4'h5), ALL});
        tbl_tag.push_back("w0_idle");

        // Reset held three cycles.
        rst_ni = 1'b0;
        drive(idle_in);
        repeat (3) @(negedge clk_i);
        check_now(idle_out(1'b0, 4'h0), ALL, "reset_state");
        rst_ni = 1'b1;
        step(idle_in, idle_out(1'b0, 4'h0), ALL, "after_reset");

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].in, tbl[k].exp, tbl[k].care, tbl_tag[k]);
        end

        // Two wraps in mode 00 from C: rco at T+7 and T+23, done at T+24.
        step(mk_in(1'b1, 2'b00, 4'hC, 4'd2, 1'b0, 1'b0, 1'b0, 4'h0),
             mk_out(1'b0, 1'b1, 1'b1, 2'b11, 4'hC, 1'b0, 1'b0, 4'h5), ALL, "w2_load");
        step(idle_in, mk_out(1'b0, 1'b1, 1'b0, 2'b11, 4'hC, 1'b0, 1'b0, 4'h5), ALL, "w2_load_wait");
        count_o = mk_out(1'b0, 1'b1, 1'b1, 2'b00, 4'hC, 1'b0, 1'b0, 4'h5);
        step(mk_in(1'b0, 2'b00, 4'h0, 4'd0, 1'b0, 1'b1, 1'b0, 4'hC), count_o, ALL, "w2_count_start");
        for (int k = 3; k <= 22; k++) begin
            v = mk_in(1'b0, 2'b00, 4'h0, 4'd0, 1'b0, 1'b0, (k == 7), 4'(12 + k - 2));
            step(v, count_o, ALL, "w2_counting");
        end
        step(mk_in(1'b0, 2'b00, 4'h0, 4'd0, 1'b0, 1'b0, 1'b1, 4'h1),
             mk_out(1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 1'b1, 1'b0, 4'h1), DONE_CARE, "w2_done");
        step(idle_in, idle_out(1'b0, 4'h1), ALL, "w2_ready");

        // Three wraps requested, one rco delivered at T+5: err TIMEOUT cycles later.
        step(mk_in(1'b1, 2'b10, 4'h3, 4'd3, 1'b0, 1'b0, 1'b0, 4'h0),
             mk_out(1'b0, 1'b1, 1'b1, 2'b11, 4'h3, 1'b0, 1'b0, 4'h1), ALL, "to_load");
        step(idle_in, mk_out(1'b0, 1'b1, 1'b0, 2'b11, 4'h3, 1'b0, 1'b0, 4'h1), ALL, "to_load_wait");
        count_o = mk_out(1'b0, 1'b1, 1'b1, 2'b10, 4'h3, 1'b0, 1'b0, 4'h1);
        step(mk_in(1'b0, 2'b00, 4'h0, 4'd0, 1'b0, 1'b1, 1'b0, 4'h3), count_o, ALL, "to_count_start");
        step(idle_in, count_o, ALL, "to_pre_rco");
        step(idle_in, count_o, ALL, "to_pre_rco");
        step(mk_in(1'b0, 2'b00, 4'h0, 4'd0, 1'b0, 1'b0, 1'b1, 4'h0), count_o, ALL, "to_rco");
        for (int j = 1; j <= TIMEOUT - 2; j++) begin
            step(idle_in, count_o, ALL, "to_waiting");
        end
        step(idle_in, idle_out(1'b1, 4'h1), ALL, "to_err");
        step(idle_in, idle_out(1'b0, 4'h1), ALL, "to_err_clear");

        // Abort on the final rco, with a second command held throughout.
        c2 = mk_in(1'b1, 2'b01, 4'h7, 4'd0, 1'b0, 1'b0, 1'b0, 4'h0);
        step(mk_in(1'b1, 2'b00, 4'hA, 4'd1, 1'b0, 1'b0, 1'b0, 4'h0),
             mk_out(1'b0, 1'b1, 1'b1, 2'b11, 4'hA, 1'b0, 1'b0, 4'h1), ALL, "ab_load");
        step(c2, mk_out(1'b0, 1'b1, 1'b0, 2'b11, 4'hA, 1'b0, 1'b0, 4'h1), ALL, "ab_held_load_wait");
        v = c2;
        v.load = 1'b1;
        v.q    = 4'hA;
        step(v, mk_out(1'b0, 1'b1, 1'b1, 2'b00, 4'hA, 1'b0, 1'b0, 4'h1), ALL, "ab_held_count");
        v = c2;
        v.rco   = 1'b1;
        v.abort = 1'b1;
        v.q     = 4'hB;
        step(v, idle_out(1'b1, 4'h1), ALL, "ab_abort_err");
        step(c2, mk_out(1'b0, 1'b1, 1'b1, 2'b11, 4'h7, 1'b0, 1'b0, 4'h1), ALL, "ab_second_load");
        step(idle_in, mk_out(1'b0, 1'b1, 1'b0, 2'b11, 4'h7, 1'b0, 1'b0, 4'h1), ALL, "ab_second_wait");
        step(mk_in(1'b0, 2'b00, 4'h0, 4'd0, 1'b0, 1'b1, 1'b0, 4'h7),
             mk_out(1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 1'b1, 1'b0, 4'h7), DONE_CARE, "ab_second_done");
        step(idle_in, idle_out(1'b0, 4'h7), ALL, "ab_second_idle");

        // Reset in the middle of a command: straight back to idle, no pulses.
        step(mk_in(1'b1, 2'b00, 4'h6, 4'd2, 1'b0, 1'b0, 1'b0, 4'h0),
             mk_out(1'b0, 1'b1, 1'b1, 2'b11, 4'h6, 1'b0, 1'b0, 4'h7), ALL, "rst_mid_load");
        step(idle_in, mk_out(1'b0, 1'b1, 1'b0, 2'b11, 4'h6, 1'b0, 1'b0, 4'h7), ALL, "rst_mid_wait");
        rst_ni = 1'b0;
        #1;
        check_now(idle_out(1'b0, 4'h0), ALL, "rst_mid_async");
        @(posedge clk_i);
        @(negedge clk_i);
        check_now(idle_out(1'b0, 4'h0), ALL, "rst_mid_held");
        rst_ni = 1'b1;
        step(idle_in, idle_out(1'b0, 4'h0), ALL, "rst_mid_release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/contador_seq_ctrl.md
Name: contador_seq_ctrl

Overview:
Command-driven sequencer for the 4-bit mode counter (contador).
- Accepts a command (count mode, start value, number of wrap events) over a valid/ready handshake.
- Loads the start value into the counter, then enables it in the requested mode until the requested number of rco pulses has been seen.
- Reports completion with the final count, or an error on illegal mode, abort or watchdog timeout.

Parameters:
WRAP_W, 4, width of cmd_wraps and of the internal remaining-wraps counter
TIMEOUT, 64, max cycles allowed between progress events (cnt_load or cnt_rco) before error; watchdog width = clog2(TIMEOUT+1)

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command (IDLE only)
cmd_mode  in  2  counter mode; 00/01/10 legal count modes, 11 (load) illegal as a count mode
cmd_start  in  4  value loaded into counter before counting
cmd_wraps  in  WRAP_W  rco pulses to wait for; 0 = load only
abort  in  1  cancel current command
cnt_enable  out  1  drives counter enable
cnt_mode  out  2  drives counter mode
cnt_D  out  4  drives counter D
cnt_load  in  1  counter load flag
cnt_rco  in  1  counter rco flag
cnt_Q  in  4  counter value
busy  out  1  high in any state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle error pulse
final_q  out  4  cnt_Q captured on completion; holds until next completion

Behaviour:
- States: IDLE, LOAD, LOAD_WAIT, COUNT, DONE.
- All outputs are Moore decodes of state or registers. There is no combinational path from inputs to outputs except none.
- While reset is low:
  - state = IDLE; remaining, watchdog, latched command = 0.
  - done = err = 0, final_q = 0.
  - cnt_enable = 0, cnt_mode = 00, cnt_D = 0.
  - busy = 0, cmd_ready = 1.
- IDLE:
  - cmd_ready = 1; cnt_enable = 0; cnt_mode = 00; cnt_D = 0.
  - On cmd_valid=1, latch mode/start/wraps.
  - If cmd_mode = 11: pulse err next cycle and stay IDLE.
  - Otherwise go to LOAD.
- LOAD (1 cycle): cnt_mode = 11, cnt_D = start, cnt_enable = 1. Then go to LOAD_WAIT; watchdog cleared.
- LOAD_WAIT:
  - cnt_mode = 11, cnt_D = start, cnt_enable = 0.
  - On cnt_load = 1: go to DONE if wraps = 0, else go to COUNT with remaining = wraps and watchdog cleared.
- COUNT:
  - cnt_mode = latched mode, cnt_enable = 1, cnt_D = start.
  - Each cycle with cnt_rco = 1: remaining decrements and the watchdog clears.
  - When cnt_rco = 1 with remaining = 1: go to DONE.
- DONE (1 cycle):
  - done = 1, cnt_enable = 0, final_q = cnt_Q (captured on the edge entering DONE).
  - Then go to IDLE.
- Watchdog:
  - Increments each cycle in LOAD_WAIT/COUNT with no progress event.
  - Reaching TIMEOUT → err pulse, go to IDLE.
- Abort:
  - abort = 1 in any non-IDLE state → IDLE next cycle, err = 1 that cycle, cnt_enable = 0.
  - Abort in IDLE is ignored.
- Priority in one cycle: abort > timeout > rco/load progress.
- Timing: command accepted at cycle T.
  - LOAD at T+1.
  - LOAD_WAIT at T+2; the counter raises cnt_load at T+2.
  - COUNT at T+3.
  - Final rco at cycle X → done at X+1, cmd_ready at X+2.
- cmd_valid while busy is not accepted; the command stays pending at the input.
- Reset asserted mid-command returns to IDLE immediately with no done/err pulse.
- remaining never underflows; cnt_rco in states other than COUNT is ignored.

Test Plan:
1. Reset low 3 cycles, then release → cmd_ready=1, busy=0, cnt_enable=0, cnt_mode=00, done=err=0, final_q=0.
2. cmd mode=00, start=4'hC, wraps=2; bench model returns cnt_load at T+2 and rco pulses at T+7 and T+23 → cnt_mode=11/cnt_D=C at T+1, cnt_enable=1 with cnt_mode=00 from T+3 to T+23, done=1 at T+24 with final_q = cnt_Q at T+23, cmd_ready=1 at T+25.
3. cmd mode=11 → no LOAD, err=1 next cycle, busy stays 0.
4. cmd wraps=0, start=4'h5 → LOAD, LOAD_WAIT, then done once cnt_load is seen; cnt_enable is never high with a count mode.
5. cmd wraps=3, TIMEOUT=64, only one rco delivered → err=1 exactly 64 cycles after that rco, then IDLE; done never asserted.
6. abort asserted in the same cycle as the final rco in COUNT → err=1, done=0, IDLE next cycle; a second cmd_valid held during busy is accepted only after cmd_ready returns.
